hs_burst_framer: RTL

- Single-clock burst buffer and framer for the high-speed byte path.
- Captures contiguous i_valid bursts into an internal RAM and commits each burst as one frame on the falling edge of i_valid.
- Replays committed frames whole, with SOF/EOF markers, ready/valid backpressure and a programmable inter-frame gap.
- Generalises the earlier fixed 8-bit, one-burst-at-a-time buffer: width, depth, queued-frame count and gap are parameters, and overflowing frames are dropped cleanly.

---
 rtl/hs_burst_framer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hs_burst_framer.sv
// hs_burst_framer: captures i_valid bursts into a RAM, commits each burst as a frame and
// replays frames with SOF/EOF, ready/valid backpressure and an inter-frame gap.
// Optional macro HS_LEN_HDR_EN prefixes every frame with a one-beat length header.
module hs_burst_framer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 4096,
   parameter int MAX_FRAMES = 8,
   parameter int GAP_CYC    = 6
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [DATA_W-1:0]                 i_data,
   input  logic                              i_valid,
   output logic [DATA_W-1:0]                 o_data,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic                              o_sof,
   output logic                              o_eof,
   output logic                              o_drop,
   output logic [$clog2(MAX_FRAMES+1)-1:0]   o_frames_pending,
   output logic                              o_busy
);
   localparam int LEN_W = $clog2(DEPTH) + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int FAW   = $clog2(MAX_FRAMES);
   localparam int CW    = $clog2(MAX_FRAMES + 1);
   localparam int GW    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_HDR  = 2'd1,
      R_DATA = 2'd2,
      R_GAP  = 2'd3
   } rd_state_t;

   logic [DATA_W-1:0] mem_r     [DEPTH];
   logic [LEN_W-1:0]  len_mem_r [MAX_FRAMES];

   logic [AW-1:0]     wr_ptr_r, burst_start_r, rd_ptr_r;
   logic [LEN_W-1:0]  cur_len_r, used_r, rd_left_r;
   logic              in_burst_r, burst_ovf_r, drop_r;
   logic [FAW-1:0]    fifo_wr_ptr_r, fifo_rd_ptr_r;
   logic [CW-1:0]     fifo_cnt_r;
   logic [GW-1:0]     gap_cnt_r;
   rd_state_t         rd_state_r;
   logic [DATA_W-1:0] data_r;
   logic              valid_r, sof_r, eof_r, busy_r;

   logic              ram_full_s, fifo_full_s, beat_wr_s, commit_s, bad_s;
   logic              push_s, rollback_s, pop_s, rel_s;
   logic [LEN_W-1:0]  used_nxt_s, head_len_s;

   // Full conditions use the pre-cycle counts; a burst that ever hit full is dropped whole.
   assign ram_full_s  = (used_r == LEN_W'(DEPTH));
   assign fifo_full_s = (fifo_cnt_r == CW'(MAX_FRAMES));
   assign beat_wr_s   = i_valid && !ram_full_s && !burst_ovf_r;
   assign commit_s    = in_burst_r && !i_valid;
   assign bad_s       = burst_ovf_r || fifo_full_s;
   assign push_s      = commit_s && !bad_s;
   assign rollback_s  = commit_s && bad_s;
   assign pop_s       = (rd_state_r == R_IDLE) && (fifo_cnt_r != {CW{1'b0}});
   assign rel_s       = (rd_state_r == R_DATA) && valid_r && i_ready;
   assign head_len_s  = len_mem_r[fifo_rd_ptr_r];

   // Occupancy covers committed and in-progress beats; released per transferred data beat.
   always_comb begin
      used_nxt_s = used_r + LEN_W'(beat_wr_s) - LEN_W'(rel_s)
                   - (rollback_s ? cur_len_r : {LEN_W{1'b0}});
   end

   // Data RAM and length FIFO storage.
   always_ff @(posedge i_clk) begin
      if (beat_wr_s) mem_r[wr_ptr_r] <= i_data;
      if (push_s) len_mem_r[fifo_wr_ptr_r] <= cur_len_r;
   end

   // Write side: burst capture, commit, rollback and length FIFO bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_r      <= {AW{1'b0}};
         burst_start_r <= {AW{1'b0}};
         cur_len_r     <= {LEN_W{1'b0}};
         used_r        <= {LEN_W{1'b0}};
         in_burst_r    <= 1'b0;
         burst_ovf_r   <= 1'b0;
         drop_r        <= 1'b0;
         fifo_wr_ptr_r <= {FAW{1'b0}};
         fifo_rd_ptr_r <= {FAW{1'b0}};
         fifo_cnt_r    <= {CW{1'b0}};
      end else begin
         in_burst_r <= i_valid;
         drop_r     <= rollback_s;
         used_r     <= used_nxt_s;
         fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
         if (push_s) fifo_wr_ptr_r <= fifo_wr_ptr_r + FAW'(1);
         if (pop_s)  fifo_rd_ptr_r <= fifo_rd_ptr_r + FAW'(1);
         if (i_valid) begin
            if (!in_burst_r) burst_start_r <= wr_ptr_r;
            if (beat_wr_s) begin
               wr_ptr_r  <= wr_ptr_r + AW'(1);
               cur_len_r <= cur_len_r + LEN_W'(1);
            end else begin
               burst_ovf_r <= 1'b1;
            end
         end else if (commit_s) begin
            if (bad_s) wr_ptr_r <= burst_start_r;
            cur_len_r   <= {LEN_W{1'b0}};
            burst_ovf_r <= 1'b0;
         end
      end
   end

   // Read FSM: pop a length, prefetch, stream the frame, then hold the gap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_state_r <= R_IDLE;
         rd_ptr_r   <= {AW{1'b0}};
         rd_left_r  <= {LEN_W{1'b0}};
         gap_cnt_r  <= {GW{1'b0}};
         data_r     <= {DATA_W{1'b0}};
         valid_r    <= 1'b0;
         sof_r      <= 1'b0;
         eof_r      <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         case (rd_state_r)
            R_IDLE: begin
               if (pop_s) begin
`ifdef HS_LEN_HDR_EN
                  data_r     <= DATA_W'(head_len_s);
                  eof_r      <= 1'b0;
                  rd_state_r <= R_HDR;
`else
                  data_r     <= mem_r[rd_ptr_r];
                  rd_ptr_r   <= rd_ptr_r + AW'(1);
                  eof_r      <= (head_len_s == LEN_W'(1));
                  rd_state_r <= R_DATA;
`endif
                  sof_r     <= 1'b1;
                  valid_r   <= 1'b1;
                  rd_left_r <= head_len_s;
                  busy_r    <= 1'b1;
               end
            end
            R_HDR: begin
               if (i_ready) begin
                  data_r     <= mem_r[rd_ptr_r];
                  rd_ptr_r   <= rd_ptr_r + AW'(1);
                  sof_r      <= 1'b0;
                  eof_r      <= (rd_left_r == LEN_W'(1));
                  rd_state_r <= R_DATA;
               end
            end
            R_DATA: begin
               if (i_ready) begin
                  if (rd_left_r == LEN_W'(1)) begin
                     valid_r <= 1'b0;
                     sof_r   <= 1'b0;
                     eof_r   <= 1'b0;
                     if (GAP_CYC > 0) begin
                        gap_cnt_r  <= GW'(GAP_CYC);
                        rd_state_r <= R_GAP;
                     end else begin
                        busy_r     <= 1'b0;
                        rd_state_r <= R_IDLE;
                     end
                  end else begin
                     data_r    <= mem_r[rd_ptr_r];
                     rd_ptr_r  <= rd_ptr_r + AW'(1);
                     rd_left_r <= rd_left_r - LEN_W'(1);
                     sof_r     <= 1'b0;
                     eof_r     <= (rd_left_r == LEN_W'(2));
                  end
               end
            end
            R_GAP: begin
               gap_cnt_r <= gap_cnt_r - GW'(1);
               if (gap_cnt_r == GW'(1)) begin
                  busy_r     <= 1'b0;
                  rd_state_r <= R_IDLE;
               end
            end
            default: begin
               rd_state_r <= R_IDLE;
               valid_r    <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign o_data           = data_r;
   assign o_valid          = valid_r;
   assign o_sof            = sof_r;
   assign o_eof            = eof_r;
   assign o_drop           = drop_r;
   assign o_busy           = busy_r;
   assign o_frames_pending = fifo_cnt_r;

endmodule
